// File: rtl/cond_decode_pkg.sv
// Shared definitions for the conditional-execution decode stage: flag
// positions, condition codes, opcode fields and instruction classification.
package cond_decode_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        HI = 4'h4,
        LS = 4'h5,
        GT = 4'h6,
        LE = 4'h7,
        FS = 4'h8,
        FC = 4'h9,
        LO = 4'hA,
        HS = 4'hB,
        LT = 4'hC,
        GE = 4'hD,
        UC = 4'hE,
        NV = 4'hF
    } cond_code_e;

    localparam logic [3:0] OP_JCOND  = 4'b0100;
    localparam logic [3:0] OP_BCOND  = 4'b1100;
    localparam logic [3:0] JCOND_SUB = 4'b1100;

    typedef enum logic [1:0] {
        IK_PLAIN = 2'd0,
        IK_JC    = 2'd1,
        IK_BC    = 2'd2,
        IK_ZERO  = 2'd3
    } instr_kind_e;

    // JC and BC opcodes are disjoint, so the order of the tests is irrelevant.
    function automatic instr_kind_e classify(input logic [15:0] w);
        instr_kind_e k;
        k = IK_PLAIN;
        if (w == 16'h0000)
            k = IK_ZERO;
        else if (w[15:12] == OP_JCOND && w[7:4] == JCOND_SUB)
            k = IK_JC;
        else if (w[15:12] == OP_BCOND)
            k = IK_BC;
        return k;
    endfunction

    function automatic logic is_conditional(input instr_kind_e k);
        return (k == IK_JC) || (k == IK_BC);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: maps a 4-bit condition code and the
// flag vector to a hit bit. Kept separate so predicated ops can reuse it.
module cond_eval
    import cond_decode_pkg::*;
#(
    parameter int FW = 5
) (
    input  logic [3:0]    cond,
    input  logic [FW-1:0] flags,
    output logic          hit
);

    logic c, l, f, z, n;

    always_comb begin
        c = flags[FLAG_C];
        l = flags[FLAG_L];
        f = flags[FLAG_F];
        z = flags[FLAG_Z];
        n = flags[FLAG_N];
    end

    always_comb begin
        hit = 1'b0;
        case (cond_code_e'(cond))
            EQ: hit = z;
            NE: hit = !z;
            CS: hit = c;
            CC: hit = !c;
            HI: hit = l;
            LS: hit = !l;
            GT: hit = n;
            LE: hit = !n;
            FS: hit = f;
            FC: hit = !f;
            LO: hit = !z && !l;
            HS: hit = z || l;
            LT: hit = !n && !c;
            GE: hit = n || c;
            UC: hit = 1'b1;
            NV: hit = 1'b0;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_decode_stage.sv
// Registered conditional-execution decode stage: resolves Jcond/Bcond against
// the flags, substitutes NOP for annulled instructions and counts annuls.
module cond_decode_stage
    import cond_decode_pkg::*;
#(
    parameter int             IW        = 16,
    parameter int             FW        = 5,
    parameter logic [IW-1:0]  NOP_WORD  = 16'h0020,
    parameter logic [IW-1:0]  HALT_WORD = 16'h0080,
    parameter int             CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_instr,
    input  logic [FW-1:0]    flags,
    input  logic             flags_pending,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_instr,
    output logic             out_taken,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] annul_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    instr_kind_e   kind;
    logic          is_cond;
    logic          hit;
    logic          stall;
    logic          accept;
    logic          annul;
    logic [IW-1:0] res_instr;
    logic          res_taken;

    assign kind    = classify(in_instr[15:0]);
    assign is_cond = is_conditional(kind);

    cond_eval #(
        .FW (FW)
    ) u_cond_eval (
        .cond  (in_instr[11:8]),
        .flags (flags),
        .hit   (hit)
    );

    always_comb begin
        res_instr = in_instr;
        res_taken = 1'b1;
        case (kind)
            IK_JC: begin
                if (hit) begin
                    res_instr[11:8] = 4'h0;
                end else begin
                    res_instr = NOP_WORD;
                    res_taken = 1'b0;
                end
            end
            IK_BC: begin
                if (!hit) begin
                    res_instr = NOP_WORD;
                    res_taken = 1'b0;
                end
            end
            IK_ZERO:  res_instr = HALT_WORD;
            default:  res_instr = in_instr;
        endcase
    end

    // Handshake: a word moves on the input side when in_valid && in_ready and
    // on the output side when out_valid && out_ready. in_ready drops while a
    // conditional waits on pending flags, during flush, or while the output
    // register holds a word that execute has not taken.
    assign stall    = in_valid && is_cond && flags_pending;
    assign in_ready = !flush && !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign annul    = accept && is_cond && !hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_instr <= NOP_WORD;
            out_taken <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= res_instr;
            out_taken <= res_taken;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clearing wins over a same-cycle annul; flush leaves statistics alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            annul_count <= '0;
        end else if (clear_stats) begin
            annul_count <= '0;
        end else if (annul && (annul_count != CNT_MAX)) begin
            annul_count <= annul_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_decode_stage.sv
// Self-checking bench for cond_decode_stage: vector table, handshake corner
// sequences, randomized traffic against a behavioural model.
module tb_cond_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0000;
    logic [4:0]  flags = 5'b0;
    logic        flags_pending = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_instr;
    logic        out_taken;
    logic        clear_stats = 1'b0;
    logic [7:0]  annul_count;

    int n_vec = 0;
    int n_miss = 0;
    int exp_cnt = 0;
    logic [15:0] exp_q[$];

    always #5 clock = ~clock;

    cond_decode_stage dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .flags         (flags),
        .flags_pending (flags_pending),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_taken     (out_taken),
        .clear_stats   (clear_stats),
        .annul_count   (annul_count)
    );

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  flg;
        logic [15:0] exp_instr;
        logic        exp_taken;
        logic        miss;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flags ordered {N,Z,F,L,C}; codes 0-9 are (flag, inverted) pairs.
    function automatic logic model_hit(input logic [3:0] code, input logic [4:0] f);
        logic [4:0] base;
        logic c, l, fl, z, n;
        c = f[0]; l = f[1]; fl = f[2]; z = f[3]; n = f[4];
        base = {fl, n, l, c, z};
        if (code < 4'd10) return base[code[3:1]] ^ code[0];
        case (code)
            4'd10:   return !(z | l);
            4'd11:   return z | l;
            4'd12:   return !(n | c);
            4'd13:   return n | c;
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_is_cond(input logic [15:0] w);
        return (w[15:12] == 4'h4 && w[7:4] == 4'hC) || (w[15:12] == 4'hC);
    endfunction

    task automatic model(input logic [15:0] w, input logic [4:0] f,
                         output logic [15:0] o, output logic t, output logic m);
        logic h;
        m = 1'b0;
        t = 1'b1;
        if (model_is_cond(w)) begin
            h = model_hit(w[11:8], f);
            m = !h;
            t = h;
            if (!h) o = 16'h0020;
            else if (w[15:12] == 4'h4) o = w & 16'hF0FF;
            else o = w;
        end else if (w == 16'h0000) begin
            o = 16'h0080;
        end else begin
            o = w;
        end
    endtask

    task automatic bump(input logic m);
        if (m) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 4))
            0: begin w[15:12] = 4'h4; w[7:4] = 4'hC; end
            1: w[15:12] = 4'hC;
            2: w = 16'h0000;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] o;
        logic        t, m, pend;
        logic [15:0] w;
        logic [4:0]  fv;
        logic [15:0] e;

        tbl[0]  = '{16'h41C3, 5'b01000, 16'h0020, 1'b0, 1'b1};
        tbl[1]  = '{16'h41C3, 5'b00000, 16'h40C3, 1'b1, 1'b0};
        tbl[2]  = '{16'hC105, 5'b00000, 16'hC105, 1'b1, 1'b0};
        tbl[3]  = '{16'hCF05, 5'b00000, 16'h0020, 1'b0, 1'b1};
        tbl[4]  = '{16'h0000, 5'b11111, 16'h0080, 1'b1, 1'b0};
        tbl[5]  = '{16'h2345, 5'b01000, 16'h2345, 1'b1, 1'b0};
        tbl[6]  = '{16'h4AC1, 5'b00000, 16'h40C1, 1'b1, 1'b0};
        tbl[7]  = '{16'h4AC1, 5'b00010, 16'h0020, 1'b0, 1'b1};
        tbl[8]  = '{16'hCD00, 5'b10000, 16'hCD00, 1'b1, 1'b0};
        tbl[9]  = '{16'hCC00, 5'b00001, 16'h0020, 1'b0, 1'b1};
        tbl[10] = '{16'h4EC7, 5'b11111, 16'h40C7, 1'b1, 1'b0};
        tbl[11] = '{16'h4FC7, 5'b11111, 16'h0020, 1'b0, 1'b1};
        tbl[12] = '{16'h4123, 5'b01000, 16'h4123, 1'b1, 1'b0};
        tbl[13] = '{16'hC800, 5'b00100, 16'hC800, 1'b1, 1'b0};

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 16'h0020);
        check("rst_out_taken", out_taken, 0);
        check("rst_annul_count", annul_count, 0);
        reset = 1'b1;

        // Vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_instr = tbl[i].instr;
            flags = tbl[i].flg;
            #1 check("tbl_in_ready", in_ready, 1);
            @(negedge clock);
            in_valid = 1'b0;
            bump(tbl[i].miss);
            check("tbl_out_valid", out_valid, 1);
            check("tbl_out_instr", out_instr, tbl[i].exp_instr);
            check("tbl_out_taken", out_taken, tbl[i].exp_taken);
            check("tbl_annul_count", annul_count, exp_cnt);
        end

        // Stall on pending flags
        @(negedge clock);
        in_valid = 1'b1;
        in_instr = 16'h40C3;
        flags = 5'b01000;
        flags_pending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_in_ready", in_ready, 0);
            @(negedge clock);
            check("stall_out_valid", out_valid, 0);
        end
        flags_pending = 1'b0;
        #1 check("unstall_in_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        check("unstall_out_valid", out_valid, 1);
        check("unstall_out_instr", out_instr, 16'h40C3);
        check("unstall_out_taken", out_taken, 1);
        @(negedge clock);
        flags_pending = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'h2345;
        #1 check("plain_pending_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        flags_pending = 1'b0;
        check("plain_pending_valid", out_valid, 1);
        check("plain_pending_instr", out_instr, 16'h2345);

        // Backpressure
        @(negedge clock);
        in_valid = 1'b1;
        in_instr = 16'h2345;
        @(negedge clock);
        check("bp_first_valid", out_valid, 1);
        check("bp_first_instr", out_instr, 16'h2345);
        out_ready = 1'b0;
        in_instr = 16'hC105;
        flags = 5'b00000;
        #1 check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_instr", out_instr, 16'h2345);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 check("bp_drain_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_instr", out_instr, 16'hC105);
        @(negedge clock);

        // Back-to-back stream, one instruction per cycle
        for (int k = 0; k <= 24; k++) begin
            @(negedge clock);
            if (k > 0) begin
                check("stream_valid", out_valid, 1);
                e = exp_q.pop_front();
                check("stream_instr", out_instr, e);
            end
            if (k < 24) begin
                w = rand_instr();
                fv = 5'($urandom);
                in_valid = 1'b1;
                in_instr = w;
                flags = fv;
                model(w, fv, o, t, m);
                exp_q.push_back(o);
                bump(m);
                #1 check("stream_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        check("stream_annul_count", annul_count, exp_cnt);

        // Flush in the offer cycle, then flush of a held result
        @(negedge clock);
        in_valid = 1'b1;
        in_instr = 16'hCF05;
        flush = 1'b1;
        #1 check("flush_in_ready", in_ready, 0);
        @(negedge clock);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_annul_count", annul_count, exp_cnt);
        @(negedge clock);
        in_valid = 1'b1;
        in_instr = 16'h2345;
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("flush_held_valid", out_valid, 1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush_held_cleared", out_valid, 0);

        // Randomized single transactions with random pending flags
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            w = rand_instr();
            fv = 5'($urandom);
            pend = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            in_instr = w;
            flags = fv;
            flags_pending = pend;
            model(w, fv, o, t, m);
            #1 check("rand_in_ready", in_ready, !(model_is_cond(w) && pend));
            if (model_is_cond(w) && pend) begin
                @(negedge clock);
                check("rand_stall_valid", out_valid, 0);
                flags_pending = 1'b0;
            end
            @(negedge clock);
            in_valid = 1'b0;
            flags_pending = 1'b0;
            bump(m);
            check("rand_out_valid", out_valid, 1);
            check("rand_out_instr", out_instr, o);
            check("rand_out_taken", out_taken, t);
            check("rand_annul_count", annul_count, exp_cnt);
        end

        // Counter saturation and clear priority
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_instr = 16'hCF05;
            flags = 5'($urandom);
            bump(1'b1);
        end
        @(negedge clock);
        in_valid = 1'b0;
        check("sat_annul_count", annul_count, 255);
        in_valid = 1'b1;
        in_instr = 16'hCF05;
        clear_stats = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        clear_stats = 1'b0;
        exp_cnt = 0;
        check("clear_annul_count", annul_count, exp_cnt);
        check("clear_out_instr", out_instr, 16'h0020);
        check("clear_out_taken", out_taken, 0);
        @(negedge clock);
        in_valid = 1'b1;
        in_instr = 16'h41C3;
        flags = 5'b01000;
        @(negedge clock);
        in_valid = 1'b0;
        bump(1'b1);
        check("after_clear_count", annul_count, exp_cnt);

        // Asynchronous reset while a result is held
        @(negedge clock);
        in_valid = 1'b1;
        in_instr = 16'h2345;
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("prereset_valid", out_valid, 1);
        #3 reset = 1'b0;
        #1;
        exp_cnt = 0;
        check("async_out_valid", out_valid, 0);
        check("async_out_instr", out_instr, 16'h0020);
        check("async_out_taken", out_taken, 0);
        check("async_annul_count", annul_count, exp_cnt);
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b1;
        in_instr = 16'hC105;
        flags = 5'b01000;
        @(negedge clock);
        in_valid = 1'b0;
        bump(1'b1);
        check("postreset_instr", out_instr, 16'h0020);
        check("postreset_count", annul_count, exp_cnt);

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cond_decode_stage.md
Name: cond_decode_stage

Overview:
- Registered, parametrised conditional-execution decode stage between fetch and execute.
- Evaluates the condition field of register-jump (Jcond) and branch (Bcond) instructions against the ALU flags.
- Passes a taken instruction, or substitutes the NOP word for an annulled one.
- Adds over the previous combinational decoder: valid/ready handshake with backpressure, stall on unresolved flags, synchronous flush, and an annul statistics counter.

Parameters:
- IW, 16, instruction width (min 16; fields below are fixed in bits [15:0], upper bits pass through).
- FW, 5, flag vector width (min 5; bits above 4 are ignored).
- NOP_WORD, 16'h0020, word issued for annulled/never instructions.
- HALT_WORD, 16'h0080, word issued for an all-zero instruction.
- CNT_W, 8, annul counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch offers in_instr.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  IW  fetched instruction.
- flags  in  FW  architectural flags: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
- flags_pending  in  1  an in-flight instruction will still write flags.
- flush  in  1  synchronous squash of the stage.
- out_valid  out  1  out_instr is valid.
- out_ready  in  1  execute accepts.
- out_instr  out  IW  decoded instruction.
- out_taken  out  1  condition true (1 for non-conditional instructions).
- clear_stats  in  1  synchronous clear of annul_count.
- annul_count  out  CNT_W  saturating count of annulled conditional instructions.

Behaviour:
- Reset (reset=0, async): out_valid=0, out_instr=NOP_WORD, out_taken=0, annul_count=0.
- Classification, on in_instr[15:0]:
  - JC: [15:12]=4'b0100 and [7:4]=4'b1100.
  - BC: [15:12]=4'b1100.
  - ZERO: all bits 0.
  - PLAIN: anything else.
- Condition code = [11:8]; hit is:
  - 0: Z; 1: !Z; 2: C; 3: !C; 4: L; 5: !L; 6: N; 7: !N; 8: F; 9: !F.
  - A: !Z&!L; B: Z|L; C: !N&!C; D: N|C.
  - E: 1 (always); F: 0 (never, always NOP_WORD).
- Result:
  - JC hit: instr with [11:8] forced to 0.
  - BC hit: instr unchanged.
  - JC/BC miss: NOP_WORD, out_taken=0.
  - ZERO: HALT_WORD.
  - PLAIN: unchanged.
- Stall: when in_valid and the instruction is JC/BC and flags_pending=1, in_ready=0. PLAIN and ZERO are never stalled by flags_pending.
- Handshake:
  - in_ready = !flush & !stall & (!out_valid | out_ready).
  - Accept = in_valid & in_ready. Flags are sampled in the accept cycle.
  - Latency is 1 cycle: the result is registered on the accept edge.
- Register update, priority order:
  1. flush: out_valid<=0; nothing is accepted that cycle.
  2. Accept: load result, out_valid<=1.
  3. out_ready & out_valid: out_valid<=0.
  4. Otherwise hold; out_instr and out_taken stay stable while out_valid & !out_ready.
- Back-to-back: with out_ready held at 1, one instruction per cycle.
- Counter:
  - Increments by 1 on an accepted JC/BC miss, including code F. Saturates at 2^CNT_W-1.
  - clear_stats has priority over increment (same-cycle increment is lost).
  - flush does not affect the counter.
- Reset mid-transfer: any held instruction is lost; the upstream refetches.

Decomposition:
- Package cond_decode_pkg holds:
  - flag index constants FLAG_C/L/F/Z/N;
  - the 4-bit condition code enum (EQ, NE, CS, CC, HI, LS, GT, LE, FS, FC, LO, HS, LT, GE, UC, NV);
  - opcode constants OP_JCOND=4'b0100, OP_BCOND=4'b1100, JCOND_SUB=4'b1100.
- Sub-module cond_eval is combinational: inputs cond[3:0] and flags, output hit. It is shared with future predicated ops.

Test Plan:
- Z=1, in 16'h41C3 (JC NE, r3) -> out 16'h0020, out_taken=0, annul_count 0->1. Z=0, same instruction -> out 16'h40C3, out_taken=1.
- BC: 16'hC105, flags=0 -> 16'hC105. 16'hCF05 -> 16'h0020. 16'h0000 -> 16'h0080. 16'h2345 -> 16'h2345 unchanged.
- flags_pending=1 with 16'h40C3 offered -> in_ready=0 for 3 cycles, no out_valid. Deassert -> accepted next edge. With 16'h2345 offered during pending -> accepted immediately.
- Backpressure: out_ready=0 for 2 cycles after a valid result -> out_instr and out_valid held, in_ready=0. out_ready=1 -> drains, then back-to-back stream at 1/cycle.
- flush in the cycle an instruction is offered -> not accepted, out_valid=0 next cycle. Async reset asserted mid-stream -> outputs at reset values immediately.
- Counter: 300 annulled instructions -> annul_count=255 (saturated). clear_stats in the same cycle as a miss -> annul_count=0.
